// File: rtl/ps_power_sum.sv
// Windowed signal-power extractor: squares samples, sums 32-sample blocks,
// and reports the running energy of the most recent 8 blocks.
module ps_power_sum #(
    parameter int DATA_WIDTH   = 16,
    parameter int UNIT_WIDTH   = 32,
    parameter int MID_WIDTH    = 37,
    parameter int OUTPUT_WIDTH = 40
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic signed [DATA_WIDTH-1:0]   din,
    output logic signed [OUTPUT_WIDTH-1:0] dout,
    output logic                           data_valid
);

    localparam int CNT_W      = MID_WIDTH - UNIT_WIDTH;
    localparam int BLOCK_LEN  = 2 ** CNT_W;
    localparam int HIST_W     = OUTPUT_WIDTH - MID_WIDTH;
    localparam int NUM_BLOCKS = 2 ** HIST_W;

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic [UNIT_WIDTH-1:0]   sq_r;
    logic                    sq_v;
    logic [CNT_W-1:0]        cnt;
    logic [MID_WIDTH-1:0]    acc;
    logic [MID_WIDTH-1:0]    hist [NUM_BLOCKS];
    logic [HIST_W:0]         fill;
    logic [OUTPUT_WIDTH-1:0] total;

    logic [MID_WIDTH-1:0]    blk;
    logic [MID_WIDTH-1:0]    oldest;
    logic [HIST_W:0]         fill_nxt;
    logic [OUTPUT_WIDTH-1:0] total_nxt;
    logic                    last;
    logic                    full;

    assign prod = din * din;

    // Until the history is full, nothing real leaves the window.
    always_comb begin
        blk       = acc + MID_WIDTH'(sq_r);
        last      = (cnt == CNT_W'(BLOCK_LEN - 1));
        full      = (fill == (HIST_W + 1)'(NUM_BLOCKS));
        oldest    = full ? hist[NUM_BLOCKS-1] : '0;
        fill_nxt  = full ? fill : fill + (HIST_W + 1)'(1);
        total_nxt = total + OUTPUT_WIDTH'(blk) - OUTPUT_WIDTH'(oldest);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sq_r       <= '0;
            sq_v       <= 1'b0;
            cnt        <= '0;
            acc        <= '0;
            fill       <= '0;
            total      <= '0;
            dout       <= '0;
            data_valid <= 1'b0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                hist[i] <= '0;
            end
        end else begin
            sq_r       <= UNIT_WIDTH'($unsigned(prod));
            sq_v       <= en;
            data_valid <= 1'b0;
            if (sq_v) begin
                cnt <= cnt + CNT_W'(1);
                if (last) begin
                    acc     <= '0;
                    hist[0] <= blk;
                    for (int i = 1; i < NUM_BLOCKS; i++) begin
                        hist[i] <= hist[i-1];
                    end
                    fill       <= fill_nxt;
                    total      <= total_nxt;
                    dout       <= $signed(total_nxt);
                    data_valid <= (fill_nxt == (HIST_W + 1)'(NUM_BLOCKS));
                end else begin
                    acc <= blk;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps_power_sum.sv
// Directed bench for ps_power_sum: block steps, window fill/drain,
// worst-case magnitude, en gaps and mid-block reset.
module tb_ps_power_sum;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic signed [15:0] din;
    logic signed [39:0] dout;
    logic               data_valid;

    int checks = 0;
    int passed = 0;
    int pulses;

    ps_power_sum dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .din        (din),
        .dout       (dout),
        .data_valid (data_valid)
    );

    always #5 clk = ~clk;

    task automatic step(input logic e, input logic signed [15:0] d);
        en  = e;
        din = d;
        @(posedge clk);
        #1;
        if (data_valid) pulses++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) step(1'b0, 16'sd0);
        rst = 1'b0;
    endtask

    // 32 accepted samples, then one bubble on which the block closes.
    task automatic block(input logic signed [15:0] d);
        pulses = 0;
        for (int i = 0; i < 32; i++) step(1'b1, d);
        chk("no_dv_inside_block", 64'(pulses), 64'd0);
        step(1'b0, 16'sd0);
    endtask

    task automatic out_chk(input string tag, input logic [63:0] exp_d,
                           input logic exp_v);
        chk({tag, "_dout"}, {24'd0, dout}, exp_d);
        chk({tag, "_dv"}, 64'(data_valid), 64'(exp_v));
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        din = '0;

        // 1: reset held with random activity
        for (int i = 0; i < 10; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom));
            out_chk("reset_hold", 64'd0, 1'b0);
        end
        rst = 1'b0;

        // en=0 forever keeps outputs at zero
        pulses = 0;
        for (int i = 0; i < 40; i++) step(1'b0, 16'($urandom));
        out_chk("en_low", 64'd0, 1'b0);
        chk("en_low_pulses", 64'(pulses), 64'd0);

        // 2: din=3, block sum 32*9=288
        for (int k = 1; k <= 8; k++) begin
            block(16'sd3);
            out_chk("din3_block", 64'(288 * k), k == 8);
        end
        step(1'b0, 16'sd0);
        out_chk("din3_hold", 64'd2304, 1'b0);
        for (int k = 0; k < 2; k++) begin
            block(16'sd3);
            out_chk("din3_steady", 64'd2304, 1'b1);
        end

        // 4: drain window with zeros after a fresh fill of 3s
        do_reset(2);
        for (int k = 1; k <= 8; k++) block(16'sd3);
        out_chk("drain_full", 64'd2304, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            block(16'sd0);
            out_chk("drain", 64'(2304 - 288 * k), 1'b1);
        end

        // 3: worst-case magnitude, block = 2**35, window = 2**38
        do_reset(2);
        block(-16'sd32768);
        out_chk("max_first", 64'd34359738368, 1'b0);
        for (int k = 2; k <= 8; k++) block(-16'sd32768);
        out_chk("max_full", 64'd274877906944, 1'b1);
        chk("max_sign", 64'(dout[39]), 64'd0);

        // 5: en alternating over 64 cycles, one block of 32*4
        do_reset(2);
        pulses = 0;
        for (int i = 0; i < 64; i++) step(i % 2 == 0, 16'sd2);
        out_chk("alt_en", 64'd128, 1'b0);
        chk("alt_en_pulses", 64'(pulses), 64'd0);

        // 6: reset mid-block discards partial data
        do_reset(2);
        for (int i = 0; i < 10; i++) step(1'b1, 16'sd100);
        do_reset(2);
        out_chk("mid_reset", 64'd0, 1'b0);
        block(16'sd1);
        out_chk("post_reset_first", 64'd32, 1'b0);
        for (int k = 2; k <= 7; k++) block(16'sd1);
        out_chk("post_reset_7", 64'd224, 1'b0);
        block(16'sd1);
        out_chk("post_reset_full", 64'd256, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
